// File: rtl/spike_inject_arbiter.sv
// Round-robin arbiter sharing the Kitten Fabric NoC inject port between spike sources,
// with a per-requester token-bucket rate limiter and a registered output stage.

package kf_pkg;
  typedef struct packed {
    logic [3:0]  dst_x;
    logic [3:0]  dst_y;
    logic [7:0]  src_core;
    logic [15:0] neuron_id;
  } spike_flit_t;
endpackage

module spike_inject_arbiter
  import kf_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned BURST_MAX     = 8,
  parameter int unsigned REFILL_PERIOD = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic [NUM_REQ-1:0] i_req_mask,
  input  logic [NUM_REQ-1:0] i_req_valid,
  output logic [NUM_REQ-1:0] o_req_ready,
  input  spike_flit_t        i_req_flit [NUM_REQ],
  output logic               o_noc_inject_valid,
  input  logic               i_noc_inject_ready,
  output spike_flit_t        o_noc_inject_flit,
  output logic [NUM_REQ-1:0] o_throttled,
  output logic [31:0]        o_flit_count
);

  localparam int unsigned TOK_W = $clog2(BURST_MAX + 1);
  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = (REFILL_PERIOD > 1) ? $clog2(REFILL_PERIOD) : 1;

  logic [TOK_W-1:0] r_tokens     [NUM_REQ];
  logic [TOK_W-1:0] w_tokens_nxt [NUM_REQ];
  logic [PTR_W-1:0] r_rr_ptr;
  logic [CNT_W-1:0] r_refill_cnt;
  logic [31:0]      r_flit_count;
  logic             r_noc_valid;
  spike_flit_t      r_noc_flit;

  logic [NUM_REQ-1:0] w_eligible;
  logic [NUM_REQ-1:0] w_grant;
  logic [PTR_W-1:0]   w_grant_idx;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic               w_found;
  logic               w_slot_free;
  logic               w_xfer;
  logic               w_refill;

  // Position k of the round-robin scan starting at base.
  function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base, input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    return PTR_W'(s % NUM_REQ);
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_eligible[i]  = i_req_valid[i] && i_req_mask[i] && (r_tokens[i] != '0);
      o_throttled[i] = i_req_valid[i] && i_req_mask[i] && (r_tokens[i] == '0);
    end
  end

  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    w_found     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && w_eligible[rr_idx(r_rr_ptr, k)]) begin
        w_found                          = 1'b1;
        w_grant_idx                      = rr_idx(r_rr_ptr, k);
        w_grant[rr_idx(r_rr_ptr, k)]     = 1'b1;
      end
    end
  end

  // Requesters never see ready while reset is held.
  assign w_slot_free = !r_noc_valid || i_noc_inject_ready;
  assign w_xfer      = w_found && i_enable && w_slot_free && !i_rst;
  assign o_req_ready = w_xfer ? w_grant : '0;
  assign w_ptr_nxt   = (32'(w_grant_idx) == NUM_REQ - 1) ? '0 : w_grant_idx + PTR_W'(1);
  assign w_refill    = (r_refill_cnt == CNT_W'(REFILL_PERIOD - 1));

  // Consume and refill in the same cycle cancel out.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_tokens_nxt[i] = r_tokens[i];
      if (o_req_ready[i] && !w_refill) begin
        w_tokens_nxt[i] = r_tokens[i] - TOK_W'(1);
      end else if (!o_req_ready[i] && w_refill && (r_tokens[i] != TOK_W'(BURST_MAX))) begin
        w_tokens_nxt[i] = r_tokens[i] + TOK_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REQ; i++) r_tokens[i] <= TOK_W'(BURST_MAX);
      r_refill_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) r_tokens[i] <= w_tokens_nxt[i];
      r_refill_cnt <= w_refill ? '0 : r_refill_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr     <= '0;
      r_flit_count <= '0;
    end else if (w_xfer) begin
      r_rr_ptr <= w_ptr_nxt;
      if (r_flit_count != '1) r_flit_count <= r_flit_count + 32'd1;
    end
  end

  // Output stage: a held flit stays stable until the NoC takes it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_noc_valid <= 1'b0;
      r_noc_flit  <= '0;
    end else if (w_xfer) begin
      r_noc_valid <= 1'b1;
      r_noc_flit  <= i_req_flit[w_grant_idx];
    end else if (i_noc_inject_ready) begin
      r_noc_valid <= 1'b0;
    end
  end

  assign o_noc_inject_valid = r_noc_valid;
  assign o_noc_inject_flit  = r_noc_flit;
  assign o_flit_count       = r_flit_count;

endmodule
